// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS ALU multi-cycle units (divider and multiplier).
package mips_alu_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } div_state_e;

endpackage

// File: rtl/divider_unit_if.sv
// Handshake and operand/result bundle for divider_unit.
// The div_zero flag exists only when DIV_ZERO_TRAP_EN is defined.
interface divider_unit_if;
    import mips_alu_pkg::*;

    logic              div_control;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
`ifdef DIV_ZERO_TRAP_EN
    logic              div_zero;

    modport master (output div_control, A, B, input hi, lo, busy, done, div_zero);
    modport slave  (input div_control, A, B, output hi, lo, busy, done, div_zero);
`else
    modport master (output div_control, A, B, input hi, lo, busy, done);
    modport slave  (input div_control, A, B, output hi, lo, busy, done);
`endif

endinterface

// File: rtl/divider_unit.sv
// Multi-cycle signed restoring divider (MIPS DIV semantics), 33 cycles per result.
// Optional feature: DIV_ZERO_TRAP_EN makes a zero divisor finish in one cycle with div_zero set.
module divider_unit
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = mips_alu_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    divider_unit_if.slave div_if
);

    localparam int CNT_W = 6;

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [2*DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic                  negQuot_q, negQuot_d;
    logic                  negRem_q, negRem_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
    logic                  trap_q, trap_d;
    logic                  divZero_q, divZero_d;
`endif

    logic [DATA_W-1:0]     magA;
    logic [DATA_W-1:0]     magB;
    logic [2*DATA_W-1:0]   shifted;
    logic [DATA_W:0]       trial;

    // The upper half of the shift register holds the partial remainder, the lower half the quotient.
    always_comb begin
        magA    = div_if.A[DATA_W-1] ? -div_if.A : div_if.A;
        magB    = div_if.B[DATA_W-1] ? -div_if.B : div_if.B;
        shifted = {shift_q[2*DATA_W-2:0], 1'b0};
        trial   = {1'b0, shifted[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        trap_d    = trap_q;
        divZero_d = divZero_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (div_if.div_control) begin
                    shift_d   = {{DATA_W{1'b0}}, magA};
                    divisor_d = magB;
                    negQuot_d = div_if.A[DATA_W-1] ^ div_if.B[DATA_W-1];
                    negRem_d  = div_if.A[DATA_W-1];
                    count_d   = '0;
                    state_d   = RUN;
`ifdef DIV_ZERO_TRAP_EN
                    trap_d    = (div_if.B == '0);
                    divZero_d = 1'b0;
`endif
                end
            end

            RUN: begin
`ifdef DIV_ZERO_TRAP_EN
                if (trap_q) begin
                    trap_d    = 1'b0;
                    divZero_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else
`endif
                begin
                    // A borrow out of the trial subtraction means restore (keep the plain shift).
                    shift_d = trial[DATA_W] ? shifted
                                            : {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(ITER_COUNT - 1)) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                lo_d    = negQuot_q ? -shift_q[DATA_W-1:0] : shift_q[DATA_W-1:0];
                hi_d    = negRem_q ? -shift_q[2*DATA_W-1:DATA_W] : shift_q[2*DATA_W-1:DATA_W];
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            trap_q    <= 1'b0;
            divZero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef DIV_ZERO_TRAP_EN
            trap_q    <= trap_d;
            divZero_q <= divZero_d;
`endif
        end
    end

    assign div_if.hi   = hi_q;
    assign div_if.lo   = lo_q;
    assign div_if.done = done_q;
    assign div_if.busy = (state_q != IDLE);
`ifdef DIV_ZERO_TRAP_EN
    assign div_if.div_zero = divZero_q;
`endif

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  reset, synchronous and active-low (reset==0 at a rising clk edge resets the block).
REQ-004 div_control  input  1  start request, sampled each edge.
REQ-005 A  input  32  signed dividend.
REQ-006 B  input  32  signed divisor.
REQ-007 hi  output  32  signed remainder (registered).
REQ-008 lo  output  32  signed quotient (registered).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when hi/lo are updated.
REQ-011 div_zero  output  1  divide-by-zero flag; present only with DIV_ZERO_TRAP_EN.

Function
REQ-012 FSM states SHALL be IDLE, RUN and FIX.
REQ-013 In IDLE with div_control==1 at edge N, A and B SHALL be latched, |A| and |B| computed, the sign flags stored, count cleared, and the FSM SHALL enter RUN; busy SHALL be 1 from edge N.
REQ-014 RUN SHALL perform one restoring-division step per edge on unsigned magnitudes: shift the remainder left with the next quotient bit, subtract |B|, restore if negative. Exactly 32 steps occur, at edges N+1..N+32.
REQ-015 FIX at edge N+33: lo = quotient, negated if sign(A)!=sign(B); hi = remainder, negated if A<0; done=1, busy=0, FSM to IDLE.
REQ-016 Latency SHALL be 33 cycles from the accepting edge to done; done SHALL be high for exactly one cycle.
REQ-017 The quotient SHALL truncate toward zero, and the remainder sign SHALL follow the dividend (MIPS DIV).
REQ-018 div_control SHALL be ignored while busy; A and B changes during RUN/FIX SHALL have no effect.
REQ-019 hi and lo SHALL hold the last result until the next done.
REQ-020 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0, with no flag.
REQ-021 div_control asserted in the same cycle done is high SHALL be accepted, because the FSM is in IDLE that cycle.

Reset
REQ-022 On reset==0: hi=0, lo=0, busy=0, done=0, div_zero=0, internal registers 0, FSM=IDLE.
REQ-023 Reset SHALL take priority over everything, including mid-RUN; the operation is aborted and no done is produced.

Configuration
REQ-024 With macro DIV_ZERO_TRAP_EN defined and B==0 accepted at edge N: at edge N+1 done=1, div_zero=1, busy=0, FSM to IDLE, and hi/lo unchanged.
REQ-025 With DIV_ZERO_TRAP_EN defined, div_zero SHALL stay high until the next accepted start, then clear at that accepting edge.
REQ-026 Without DIV_ZERO_TRAP_EN: the div_zero port does not exist, and B==0 runs the full 33 cycles.
REQ-027 Without DIV_ZERO_TRAP_EN, B==0 SHALL yield hi=A, with lo=0xFFFFFFFF if A>=0 and lo=0x00000001 if A<0.

Structure
REQ-028 Shared package mips_alu_pkg SHALL hold DATA_W, ITER_COUNT=32 and the divider state enum (IDLE/RUN/FIX); the multiplier shares it.
REQ-029 The block SHALL be a single module; no sub-module is required.
REQ-030 The 6-bit iteration counter and the 64-bit remainder/quotient shift register SHALL be internal.

Verification
REQ-031 A=100, B=7, start -> done at cycle 33, lo=14, hi=2.
REQ-032 A=-100, B=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE.
REQ-033 A=100, B=-7 -> lo=0xFFFFFFF2, hi=2.
REQ-034 A=-100, B=-7 -> lo=14, hi=0xFFFFFFFE.
REQ-035 A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 A=5, B=0: with the macro, done and div_zero at cycle 1 and hi/lo unchanged; without it, done at cycle 33, hi=5, lo=0xFFFFFFFF.
REQ-037 Start A=100, B=7; pulse div_control with A=9, B=3 at cycle 10; reset==0 at cycle 20 of a second run -> first run yields 14/2, the second start is ignored, the reset run gives no done, and all outputs are 0.
